ddr2_ref_arb: RTL
=================

Name: ddr2_ref_arb

Overview:
Command-bus arbiter and auto-refresh scheduler for the DDR2 controller, placed inside ddr2_top between the init sequencer / two command requesters and the ddr2_* command pins. After init_done it generates refresh requests every T_REFI cycles and issues PRECHARGE ALL + AUTO REFRESH with tRP/tRFC spacing. It also grants exclusive bus ownership round-robin to two requesters. It drives registered cs_n/ras_n/cas_n/we_n/ba/addr.

Parameters:
ADDR_BITS, 13, DDR2 address width
BA_BITS, 2, bank address width
T_REFI, 1560, refresh interval in ck cycles (7.8 us at 200 MHz)
T_RP, 3, precharge-to-refresh cycles
T_RFC, 26, refresh-to-next-command cycles
MAX_PEND, 8, saturation value of the pending-refresh count
URGENT_TH, 4, pending count at which refresh beats requesters

Ports:
ck  in  1  clock
rst_n  in  1  synchronous active-low reset
init_done  in  1  init sequence complete; enables scheduler
req0 / req1  in  1  bus request, requester 0 / 1
cmd0 / cmd1  in  3  {ras_n,cas_n,we_n} from owner
ba0 / ba1  in  BA_BITS  bank address from owner
addr0 / addr1  in  ADDR_BITS  address from owner
gnt  out  2  one-hot grant (bit i = requester i)
ref_busy  out  1  precharge/refresh sequence in progress
ref_urgent  out  1  ref_pend >= URGENT_TH
ref_pend  out  4  pending refresh count
ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n  out  1 each  command pins, registered
ddr2_ba  out  BA_BITS  registered
ddr2_addr  out  ADDR_BITS  registered

Behaviour:
- Clock is ck. Reset is rst_n, synchronous and active-low.
- Reset values: cs_n/ras_n/cas_n/we_n = 1, ba = 0, addr = 0, gnt = 0, ref_busy = 0, ref_urgent = 0, ref_pend = 0, refi counter = 0, FSM = IDLE, last owner = 1 (so requester 0 wins first).
- init_done=0: FSM held in IDLE, refi counter held at 0, no grants, cs_n = 1.
- refi counter runs 0..T_REFI-1 while init_done=1. On wrap, ref_pend increments, saturating at MAX_PEND.
- A simultaneous increment and REF issue leaves ref_pend unchanged.
- FSM states: IDLE, GRANT, PRE, WAIT_RP, REF, WAIT_RFC.
- IDLE (pins NOP, cs_n = 1):
  - If ref_pend != 0 and (no req, or ref_pend >= URGENT_TH) -> PRE.
  - Else if any req -> GRANT. If both requesters request, grant the one that is not the last owner. gnt is asserted on entry.
- GRANT:
  - Each cycle the owner's cmd/ba/addr is registered to the pins with cs_n = 0; pin latency is 1 cycle.
  - When the owner's req = 0: gnt clears, last owner is updated, pins go to NOP (cs_n = 1), FSM -> IDLE.
  - There is no forced preemption. Requesters are required to release when ref_urgent is high.
- PRE, 1 cycle: PRECHARGE ALL (ras_n=0, cas_n=1, we_n=0, addr[10]=1, other addr bits = 0, ba = 0).
- WAIT_RP: NOP for T_RP-1 cycles, so REF reaches the pins exactly T_RP cycles after PRE.
- REF, 1 cycle: AUTO REFRESH (ras_n=0, cas_n=0, we_n=1); ref_pend decrements.
- WAIT_RFC: NOP for T_RFC-1 cycles, then -> IDLE. The earliest next command is T_RFC cycles after REF.
- ref_busy = 1 in PRE, WAIT_RP, REF and WAIT_RFC.
- ref_urgent is combinational from ref_pend.
- A wait counter is loaded on entry to each WAIT state.
- Reset asserted in any state, including mid-WAIT_RFC or GRANT, restores all reset values at the next edge.

Optional Feature:
DDR2_REF_BURST_EN
- Defined: after WAIT_RFC, if ref_pend != 0, FSM goes directly to REF (no new PRE). All pending refreshes are issued back-to-back, spaced T_RFC, behind a single PRECHARGE ALL.
- Undefined: exactly one REF per sequence; FSM returns to IDLE after WAIT_RFC.

Test Plan:
1. rst_n=0 for 4 cycles, then init_done=0 for 100 cycles -> cs_n=1, gnt=0, ref_pend=0 throughout.
2. Override T_REFI=100; init_done=1, no req -> ref_pend=1 at cycle 100; PRE on pins; REF exactly 3 cycles later; ref_pend back to 0; next command no earlier than 26 cycles after REF.
3. req0 and req1 both held, owner drops req for 1 cycle after each 5-cycle grant -> gnt sequence 01, 10, 01. Owner's cmd appears on pins 1 cycle after input with cs_n=0.
4. req0 holds bus through 9 refresh intervals (T_REFI=100) -> ref_pend saturates at 8 and ref_urgent rises when ref_pend=4. After release, with req1 high, PRE is issued before any new grant.
5. Refi wrap in the same cycle as REF with ref_pend=2 -> ref_pend stays 2. rst_n=0 during WAIT_RFC -> all outputs at reset values next cycle.
6. DDR2_REF_BURST_EN defined, ref_pend=3, no req -> one PRE, then three REFs spaced 26 cycles apart, ending with ref_pend=0. Without the macro -> three separate PRE+REF pairs.

Source files
------------

// File: rtl/ddr2_ref_arb_if.sv
// Requester side of the DDR2 command-bus arbiter: two request/command channels
// and the one-hot grant returned to them.
interface ddr2_ref_arb_if #(
    parameter int ADDR_BITS = 13,
    parameter int BA_BITS   = 2
);
    // Handshake: requester i raises req_i and keeps it high for as long as it wants
    // the bus. It owns the bus, and its cmd/ba/addr go to the pins, while gnt[i] = 1.
    // It releases the bus by dropping req_i for at least one cycle. The bus is never
    // taken away, so an owner must release it when ref_urgent is high.
    logic                 req0;
    logic                 req1;
    logic [2:0]           cmd0;
    logic [2:0]           cmd1;
    logic [BA_BITS-1:0]   ba0;
    logic [BA_BITS-1:0]   ba1;
    logic [ADDR_BITS-1:0] addr0;
    logic [ADDR_BITS-1:0] addr1;
    logic [1:0]           gnt;

    modport master (output req0, req1, cmd0, cmd1, ba0, ba1, addr0, addr1, input gnt);
    modport slave  (input req0, req1, cmd0, cmd1, ba0, ba1, addr0, addr1, output gnt);
endinterface

// File: rtl/ddr2_ref_arb.sv
// DDR2 command-bus arbiter with auto-refresh scheduler (PRECHARGE ALL + AUTO REFRESH).
// Define DDR2_REF_BURST_EN to issue all pending refreshes behind a single precharge.
module ddr2_ref_arb #(
    parameter int ADDR_BITS = 13,
    parameter int BA_BITS   = 2,
    parameter int T_REFI    = 1560,
    parameter int T_RP      = 3,
    parameter int T_RFC     = 26,
    parameter int MAX_PEND  = 8,
    parameter int URGENT_TH = 4
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic                 init_done,
    ddr2_ref_arb_if.slave        bus,
    output logic                 ref_busy,
    output logic                 ref_urgent,
    output logic [3:0]           ref_pend,
    output logic                 ddr2_cs_n,
    output logic                 ddr2_ras_n,
    output logic                 ddr2_cas_n,
    output logic                 ddr2_we_n,
    output logic [BA_BITS-1:0]   ddr2_ba,
    output logic [ADDR_BITS-1:0] ddr2_addr,
    output logic [2:0]           fsm_state
);

    // WAIT states last T_RP-1 / T_RFC-1 cycles, so both timings must be at least 2.
    localparam int REFI_W   = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam int WAIT_MAX = (T_RFC > T_RP) ? T_RFC : T_RP;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT    = 3'd1,
        S_PRE      = 3'd2,
        S_WAIT_RP  = 3'd3,
        S_REF      = 3'd4,
        S_WAIT_RFC = 3'd5
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [REFI_W-1:0]    refi_cnt;
    logic                 refi_wrap;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 owner;
    logic                 pick;
    logic                 any_req;
    logic                 owner_req;
    logic                 ref_issue;

    logic                 cs_nxt;
    logic [2:0]           cmd_nxt;
    logic [BA_BITS-1:0]   ba_nxt;
    logic [ADDR_BITS-1:0] addr_nxt;

    assign any_req   = bus.req0 | bus.req1;
    assign owner_req = owner ? bus.req1 : bus.req0;
    // owner doubles as "last owner": on a tie the other requester wins.
    assign pick      = (bus.req0 & bus.req1) ? ~owner : bus.req1;
    assign refi_wrap = init_done && (refi_cnt == REFI_W'(T_REFI - 1));
    assign ref_issue = (state == S_REF);

    always_ff @(posedge ck) begin
        if (!rst_n || !init_done) begin
            refi_cnt <= '0;
        end else if (refi_wrap) begin
            refi_cnt <= '0;
        end else begin
            refi_cnt <= refi_cnt + 1'b1;
        end
    end

    // A wrap coinciding with a REF cancels out.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            ref_pend <= '0;
        end else if (refi_wrap && !ref_issue) begin
            if (ref_pend != 4'(MAX_PEND)) begin
                ref_pend <= ref_pend + 1'b1;
            end
        end else if (ref_issue && !refi_wrap) begin
            if (ref_pend != '0) begin
                ref_pend <= ref_pend - 1'b1;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            owner    <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_WAIT_RP && state != S_WAIT_RP) begin
                wait_cnt <= WAIT_W'(T_RP - 2);
            end else if (state_nxt == S_WAIT_RFC && state != S_WAIT_RFC) begin
                wait_cnt <= WAIT_W'(T_RFC - 2);
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == S_IDLE && state_nxt == S_GRANT) begin
                owner <= pick;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ref_pend != '0 && (!any_req || ref_urgent)) begin
                    state_nxt = S_PRE;
                end else if (any_req) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!owner_req) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PRE: state_nxt = S_WAIT_RP;
            S_WAIT_RP: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_REF;
                end
            end
            S_REF: state_nxt = S_WAIT_RFC;
            S_WAIT_RFC: begin
                if (wait_cnt == '0) begin
`ifdef DDR2_REF_BURST_EN
                    state_nxt = (ref_pend != '0) ? S_REF : S_IDLE;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!init_done) begin
            state_nxt = S_IDLE;
        end
    end

    // Pin values for the next cycle are decoded from the current state.
    always_comb begin
        cs_nxt   = 1'b1;
        cmd_nxt  = CMD_NOP;
        ba_nxt   = '0;
        addr_nxt = '0;
        case (state)
            S_GRANT: begin
                if (owner_req) begin
                    cs_nxt   = 1'b0;
                    cmd_nxt  = owner ? bus.cmd1  : bus.cmd0;
                    ba_nxt   = owner ? bus.ba1   : bus.ba0;
                    addr_nxt = owner ? bus.addr1 : bus.addr0;
                end
            end
            S_PRE: begin
                cs_nxt   = 1'b0;
                cmd_nxt  = CMD_PRE;
                addr_nxt = ADDR_BITS'(1) << 10;
            end
            S_REF: begin
                cs_nxt  = 1'b0;
                cmd_nxt = CMD_REF;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.gnt    = 2'b00;
        if (state == S_GRANT) begin
            bus.gnt = owner ? 2'b10 : 2'b01;
        end
        ref_busy   = (state == S_PRE) || (state == S_WAIT_RP) ||
                     (state == S_REF) || (state == S_WAIT_RFC);
        ref_urgent = (ref_pend >= 4'(URGENT_TH));
        fsm_state  = state;
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            ddr2_cs_n  <= 1'b1;
            ddr2_ras_n <= 1'b1;
            ddr2_cas_n <= 1'b1;
            ddr2_we_n  <= 1'b1;
            ddr2_ba    <= '0;
            ddr2_addr  <= '0;
        end else begin
            ddr2_cs_n  <= cs_nxt;
            ddr2_ras_n <= cmd_nxt[2];
            ddr2_cas_n <= cmd_nxt[1];
            ddr2_we_n  <= cmd_nxt[0];
            ddr2_ba    <= ba_nxt;
            ddr2_addr  <= addr_nxt;
        end
    end

endmodule
